// File: rtl/i2s_pkg.sv
// Shared types and frame geometry for the I2S transmit scheduler.
package i2s_pkg;

  typedef enum logic [1:0] {IDLE, FILL, RUN} i2s_sched_state_e;

  localparam int SLOT_BITS = 32;

  // clk cycles in one left+right frame
  function automatic int frame_cycles(input int mclk_div, input int sclk_div);
    return mclk_div * sclk_div * 2 * SLOT_BITS;
  endfunction

endpackage

// File: rtl/i2s_clk_div.sv
// Frame phase counter P with registered mclk/sclk/lrck and slot strobes.
module i2s_clk_div
  import i2s_pkg::*;
#(
  parameter int MCLK_DIV = 4,
  parameter int SCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic mclk,
  output logic sclk,
  output logic lrck,
  output logic slot_start_l,
  output logic slot_start_r,
  output logic slot_end
);

  localparam int FRAME = frame_cycles(MCLK_DIV, SCLK_DIV);
  localparam int PW    = $clog2(FRAME);
  localparam int MB    = $clog2(MCLK_DIV) - 1;
  localparam int SB    = $clog2(MCLK_DIV * SCLK_DIV) - 1;
  localparam logic [PW-1:0] HALF    = PW'(FRAME / 2);
  localparam logic [PW-1:0] HALF_M1 = PW'(FRAME / 2 - 1);
  localparam logic [PW-1:0] LAST    = PW'(FRAME - 1);

  logic [PW-1:0] p;

  // FRAME is a power of two, so P wraps on its own
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p    <= '0;
      mclk <= 1'b0;
      sclk <= 1'b0;
      lrck <= 1'b0;
    end else if (!run) begin
      p    <= '0;
      mclk <= 1'b0;
      sclk <= 1'b0;
      lrck <= 1'b0;
    end else begin
      p    <= p + 1'b1;
      mclk <= p[MB];
      sclk <= p[SB];
      lrck <= p[PW-1];
    end
  end

  assign slot_start_l = run && (p == '0);
  assign slot_start_r = run && (p == HALF);
  assign slot_end     = run && ((p == HALF_M1) || (p == LAST));

endmodule

// File: rtl/i2s_tx_sched.sv
// I2S transmit scheduler: primes left/right holds, emits one word per lrck slot,
// substitutes zero on underrun and drops words not accepted within their slot.
module i2s_tx_sched
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int MCLK_DIV   = 4,
  parameter int SCLK_DIV   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] axis_l_tdata,
  input  logic                  axis_l_tvalid,
  output logic                  axis_l_tready,
  input  logic [DATA_WIDTH-1:0] axis_r_tdata,
  input  logic                  axis_r_tvalid,
  output logic                  axis_r_tready,
  output logic [DATA_WIDTH-1:0] axis_tx_tdata,
  output logic                  axis_tx_tvalid,
  input  logic                  axis_tx_tready,
  output logic                  axis_tx_tlast,
  output logic                  mclk,
  output logic                  sclk,
  output logic                  lrck,
  output logic                  underrun,
  output logic                  late,
  output logic [15:0]           underrun_cnt
);

  i2s_sched_state_e state, state_nxt;
  logic                  run, start_l, start_r, slot_end;
  logic                  full_l, full_r, hs_l, hs_r, cur_full;
  logic [DATA_WIDTH-1:0] hold_l, hold_r, cur_hold;

  assign run = en && (state == RUN);

  i2s_clk_div #(.MCLK_DIV(MCLK_DIV), .SCLK_DIV(SCLK_DIV)) u_clk_div (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .mclk         (mclk),
    .sclk         (sclk),
    .lrck         (lrck),
    .slot_start_l (start_l),
    .slot_start_r (start_r),
    .slot_end     (slot_end)
  );

  // rst gating keeps tready low while reset is held even if en is high
  assign axis_l_tready = en & ~full_l & ~rst;
  assign axis_r_tready = en & ~full_r & ~rst;
  assign hs_l = axis_l_tvalid & axis_l_tready;
  assign hs_r = axis_r_tvalid & axis_r_tready;

  // a same-cycle load wins over the slot-start clear: the clear consumed the old word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_l <= 1'b0;
      full_r <= 1'b0;
      hold_l <= '0;
      hold_r <= '0;
    end else if (!en) begin
      full_l <= 1'b0;
      full_r <= 1'b0;
    end else begin
      if (hs_l) begin
        hold_l <= axis_l_tdata;
        full_l <= 1'b1;
      end else if (start_l) begin
        full_l <= 1'b0;
      end
      if (hs_r) begin
        hold_r <= axis_r_tdata;
        full_r <= 1'b1;
      end else if (start_r) begin
        full_r <= 1'b0;
      end
    end
  end

  assign cur_full = start_r ? full_r : full_l;
  assign cur_hold = start_r ? hold_r : hold_l;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      axis_tx_tvalid <= 1'b0;
      axis_tx_tdata  <= '0;
      axis_tx_tlast  <= 1'b0;
      underrun       <= 1'b0;
      late           <= 1'b0;
      underrun_cnt   <= '0;
    end else begin
      underrun <= 1'b0;
      late     <= 1'b0;
      if (!en) begin
        axis_tx_tvalid <= 1'b0;
      end else if (start_l || start_r) begin
        axis_tx_tvalid <= 1'b1;
        axis_tx_tlast  <= start_r;
        if (cur_full) begin
          axis_tx_tdata <= cur_hold;
        end else begin
          axis_tx_tdata <= '0;
          underrun      <= 1'b1;
          if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
        end
      end else if (axis_tx_tvalid && axis_tx_tready) begin
        axis_tx_tvalid <= 1'b0;
      end else if (axis_tx_tvalid && slot_end) begin
        axis_tx_tvalid <= 1'b0;
        late           <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = FILL;
      FILL:    if (full_l && full_r) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (!en) state_nxt = IDLE;
  end

endmodule
